// File: rtl/dac_pkg.sv
// dac_pkg: shared constants, register offsets and FSM state type for the
// DAC update sequencer.
package dac_pkg;

  // Command code understood by the DAC controller: load a new channel value.
  localparam logic [15:0] DAC_CMD_NEW_VALUE = 16'h0001;

  // Register offsets within this block's command-bus slot (cmd_bus_addr[7:0]).
  localparam logic [7:0] VALUE_BASE = 8'h00;
  localparam logic [7:0] ID         = 8'h09;
  localparam logic [7:0] CTRL       = 8'h10;
  localparam logic [7:0] STATUS     = 8'h20;

  // Identification word returned at the ID offset.
  localparam logic [15:0] ID_VALUE = 16'h05EC;

  // Scheduler states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } seq_state_e;

  // Word shipped to the DAC controller: {0, channel, 12-bit value}.
  function automatic logic [15:0] make_dac_word(input logic [2:0] ch,
                                                input logic [11:0] value);
    return {1'b0, ch, value};
  endfunction

endpackage

// File: rtl/dac_sequencer_sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing the DAC controller's busy flag
// (generated in the sclk domain) into ebi_clk.
module sync_2ff (
  input  logic ebi_clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge ebi_clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dac_sequencer.sv
// dac_sequencer: host-writable per-channel DAC values, issued round-robin to
// the DAC controller one write at a time, pacing each write on the
// controller's busy handshake.
// Optional build macro: DAC_SEQ_AUTO_REFRESH_EN adds a periodic refresh
// counter that re-flags every channel as pending while ctrl[0] is set.
module dac_sequencer
  import dac_pkg::*;
#(
  parameter int POSITION       = 65,
  parameter int DAC_POSITION   = 64,
  parameter int NUM_CHANNELS   = 8,
  parameter int BUSY_TIMEOUT   = 64,
  parameter int REFRESH_PERIOD = 1_000_000
) (
  input  logic        ebi_clk,
  input  logic        reset,
  input  logic        cmd_bus_enable,
  input  logic        cmd_bus_wr,
  input  logic        re,
  input  logic [15:0] cmd_bus_addr,
  input  logic [31:0] cmd_bus_data,
  output logic [15:0] out_data,
  output logic        dac_cmd_enable,
  output logic        dac_cmd_wr,
  output logic [15:0] dac_cmd_addr,
  output logic [31:0] dac_cmd_data,
  input  logic        dac_busy
);

  localparam logic [7:0] SLOT      = 8'(POSITION);
  localparam logic [7:0] DAC_SLOT  = 8'(DAC_POSITION);
  localparam logic [7:0] CH_MASK   = 8'((1 << NUM_CHANNELS) - 1);
  localparam logic [2:0] LAST_CH   = 3'(NUM_CHANNELS - 1);
  localparam int         TIMER_W   = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);

  // Host bus decode
  logic       cs;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] reg_addr;
  logic [7:0] chan_wr;
  logic       flush;
  logic       refresh_hit;

  // Register file and scheduler state
  logic [11:0]        value_q [8];
  logic [15:0]        chan_word [8];
  logic [7:0]         pending_q, pending_d;
  logic [7:0]         clr_mask, rep_mask, set_mask;
  logic [2:0]         last_ch_q, last_ch_d;
  logic [2:0]         cur_ch_q, cur_ch_d;
  logic [3:0]         err_cnt_q, err_cnt_d;
  logic               ctrl_en_q, ctrl_en_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  seq_state_e         state_q, state_d;
  logic               busy_s;
  logic [3:0]         pick;

  // Registered outputs
  logic [15:0] out_data_q, out_data_d;
  logic        dac_en_q, dac_en_d;
  logic        dac_wr_q, dac_wr_d;
  logic [15:0] dac_addr_q, dac_addr_d;
  logic [31:0] dac_data_q, dac_data_d;

  logic unused_data_bits;
  assign unused_data_bits = ^cmd_bus_data[31:12];

  assign cs       = cmd_bus_enable && (cmd_bus_addr[15:8] == SLOT);
  assign wr_en    = cs && cmd_bus_wr;
  assign rd_en    = cs && re;
  assign reg_addr = cmd_bus_addr[7:0];
  assign flush    = wr_en && (reg_addr == CTRL) && cmd_bus_data[1];

  // Per-channel write strobes and outgoing words; channels beyond
  // NUM_CHANNELS never decode and always read as zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_chan
    if (gi < NUM_CHANNELS) begin : g_live
      assign chan_wr[gi] = wr_en && (reg_addr == (VALUE_BASE + 8'(gi)));
    end else begin : g_dead
      assign chan_wr[gi] = 1'b0;
    end
    assign chan_word[gi] = make_dac_word(3'(gi), value_q[gi]);
  end

  sync_2ff u_busy_sync (
    .ebi_clk (ebi_clk),
    .reset   (reset),
    .d_i     (dac_busy),
    .q_o     (busy_s)
  );

`ifdef DAC_SEQ_AUTO_REFRESH_EN
  localparam logic [31:0] REFRESH_RELOAD = 32'(REFRESH_PERIOD - 1);
  logic [31:0] refresh_cnt_q;

  // Refresh down-counter: runs only while enabled, reloads on expiry or disable.
  always_ff @(posedge ebi_clk) begin
    if (reset || !ctrl_en_q || (refresh_cnt_q == 32'd0)) begin
      refresh_cnt_q <= REFRESH_RELOAD;
    end else begin
      refresh_cnt_q <= refresh_cnt_q - 32'd1;
    end
  end

  assign refresh_hit = ctrl_en_q && (refresh_cnt_q == 32'd0);
`else
  logic unused_refresh;
  assign unused_refresh = (REFRESH_PERIOD == 0);
  assign refresh_hit    = 1'b0;
`endif

  // First pending channel strictly after 'last', wrapping; returns {found, ch}.
  // Offsets are scanned far-to-near so the nearest hit is the one kept.
  function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last);
    logic [3:0] res;
    int         idx;
    res = 4'd0;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

  assign pick = rr_pick(pending_q, last_ch_q);

  // Host-side pending sources: value writes, explicit flush, periodic refresh.
  assign set_mask = chan_wr | {8{flush | refresh_hit}};

  // Scheduler next-state, strobe generation and pending-bit bookkeeping.
  always_comb begin
    state_d    = state_q;
    last_ch_d  = last_ch_q;
    cur_ch_d   = cur_ch_q;
    err_cnt_d  = err_cnt_q;
    timer_d    = timer_q;
    clr_mask   = 8'd0;
    rep_mask   = 8'd0;
    dac_en_d   = 1'b0;
    dac_wr_d   = 1'b0;
    dac_addr_d = 16'd0;
    dac_data_d = 32'd0;

    case (state_q)
      IDLE: begin
        if (pick[3]) begin
          cur_ch_d           = pick[2:0];
          clr_mask[pick[2:0]] = 1'b1;
          dac_en_d           = 1'b1;
          dac_wr_d           = 1'b1;
          dac_addr_d         = {DAC_SLOT, 8'h00};
          dac_data_d         = {DAC_CMD_NEW_VALUE, chan_word[pick[2:0]]};
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (busy_s) begin
          state_d = WAIT_FALL;
        end else if (timer_q == TIMER_LAST) begin
          if (err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 4'd1;
          rep_mask[cur_ch_q] = 1'b1;
          state_d            = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_FALL: begin
        if (!busy_s) begin
          last_ch_d = cur_ch_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A set in the same cycle as the issue-clear wins, so a value written
    // while its channel is being issued goes out again on the next sweep.
    pending_d = ((pending_q & ~clr_mask) | set_mask | rep_mask) & CH_MASK;
  end

  // Host read mux; anything unmapped or not selected reads as zero.
  always_comb begin
    out_data_d = 16'd0;
    ctrl_en_d  = ctrl_en_q;
    if (rd_en) begin
      case (reg_addr)
        ID:      out_data_d = ID_VALUE;
        STATUS:  out_data_d = {err_cnt_q, 3'b000, (state_q != IDLE), pending_q};
        default: out_data_d = 16'd0;
      endcase
    end
    if (wr_en && (reg_addr == CTRL)) ctrl_en_d = cmd_bus_data[0];
  end

  // State, register file and output registers.
  always_ff @(posedge ebi_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= 8'd0;
      last_ch_q  <= LAST_CH;
      cur_ch_q   <= 3'd0;
      err_cnt_q  <= 4'd0;
      ctrl_en_q  <= 1'b0;
      timer_q    <= '0;
      out_data_q <= 16'd0;
      dac_en_q   <= 1'b0;
      dac_wr_q   <= 1'b0;
      dac_addr_q <= 16'd0;
      dac_data_q <= 32'd0;
      for (int i = 0; i < 8; i++) value_q[i] <= 12'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      last_ch_q  <= last_ch_d;
      cur_ch_q   <= cur_ch_d;
      err_cnt_q  <= err_cnt_d;
      ctrl_en_q  <= ctrl_en_d;
      timer_q    <= timer_d;
      out_data_q <= out_data_d;
      dac_en_q   <= dac_en_d;
      dac_wr_q   <= dac_wr_d;
      dac_addr_q <= dac_addr_d;
      dac_data_q <= dac_data_d;
      for (int i = 0; i < 8; i++) begin
        if (chan_wr[i]) value_q[i] <= cmd_bus_data[11:0];
      end
    end
  end

  assign out_data       = out_data_q;
  assign dac_cmd_enable = dac_en_q;
  assign dac_cmd_wr     = dac_wr_q;
  assign dac_cmd_addr   = dac_addr_q;
  assign dac_cmd_data   = dac_data_q;

endmodule

// File: doc/dac_sequencer.md
# dac_sequencer

Multi-channel update scheduler for the serial DAC controller (command-bus slot 64). Host software writes per-channel 12-bit values into this block over the EBI command bus. The block round-robins over channels with pending updates and issues one `DAC_CMD_NEW_VALUE` write per channel to the DAC controller. After each write it waits out the controller's busy handshake before issuing the next, so the host never polls DAC busy itself.

## Interface
Parameters:
- POSITION, 65, command-bus slot of this block (`cmd_bus_addr[15:8]`)
- DAC_POSITION, 64, command-bus slot of the DAC controller
- NUM_CHANNELS, 8, channel count (max 8, 3-bit channel field)
- BUSY_TIMEOUT, 64, ebi_clk cycles to wait for dac_busy rise
- REFRESH_PERIOD, 1_000_000, ebi_clk cycles between auto-refresh sweeps

Ports:
- Clocking and reset: clock `ebi_clk`; reset `reset`, synchronous, active-high.
- ebi_clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cmd_bus_enable  in  1  host bus enable
- cmd_bus_wr  in  1  host write strobe
- re  in  1  host read strobe
- cmd_bus_addr  in  16  host address
- cmd_bus_data  in  32  host write data
- out_data  out  16  host read data, registered
- dac_cmd_enable  out  1  bus enable toward DAC controller
- dac_cmd_wr  out  1  write strobe toward DAC controller
- dac_cmd_addr  out  16  `{DAC_POSITION[7:0], 8'h00}` during issue, else 0
- dac_cmd_data  out  32  `{16'h0001, dac_word}` during issue, else 0
- dac_busy  in  1  DAC controller busy (sclk domain, asynchronous here)

## Operation
- The block is selected when `cs = cmd_bus_enable & (cmd_bus_addr[15:8] == POSITION)`.
- Write map (`cmd_bus_addr[7:0]`):
  - 0x00–0x07: `value[ch] <= data[11:0]`; sets `pending[ch]`. Addresses at or above NUM_CHANNELS are ignored.
  - 0x10: `ctrl[0]` = auto-refresh enable. Writing 1 to `data[1]` sets all pending bits (flush).
- Read map:
  - 0x09 → 16'h05EC (ID).
  - 0x20 → `{err_cnt[3:0], 3'b0, state_busy, pending[7:0]}`.
  - Any other address, or no read, → 0.
- DAC word: `dac_word = {1'b0, ch[2:0], value[ch][11:0]}`.
- dac_busy passes through a two-flop synchronizer, giving `busy_s`.
- Scheduler FSM:
  - IDLE: if `pending != 0`, select the first pending channel strictly after `last_ch`, wrapping. Latch its word, clear its pending bit, go to ISSUE.
  - ISSUE (exactly 1 cycle): assert `dac_cmd_enable` and `dac_cmd_wr`, drive addr/data. Go to WAIT_RISE with the timer cleared.
  - WAIT_RISE: on `busy_s == 1` go to WAIT_FALL. If the timer reaches BUSY_TIMEOUT−1, increment `err_cnt` (saturating at 15), re-set the pending bit for that channel, and go to IDLE.
  - WAIT_FALL: on `busy_s == 0`, set `last_ch <= ch` and go to IDLE. There is no timeout in this state.
- Simultaneous host write and issue of the same channel: the issued word carries the old value, and the pending bit stays set (set wins over clear). The new value goes out on the next sweep.
- Host writes are accepted in every state; there is no back-pressure toward the host.
- Reset, including mid-transfer:
  - State returns to IDLE.
  - All values, pending bits, `err_cnt` and ctrl are cleared.
  - `last_ch` is set to NUM_CHANNELS−1, so channel 0 is served first.
  - Strobes drop on the next edge. A DAC transfer already in flight completes on its own.

## Timing
- Reset values: out_data 0, dac_cmd_enable 0, dac_cmd_wr 0, dac_cmd_addr 0, dac_cmd_data 0.
- out_data is valid 1 cycle after the cycle in which `cs & re` is high.
- Host write in cycle N → pending visible in N+1 → ISSUE strobe in N+2 (if IDLE).
- Minimum spacing between ISSUE strobes is 2 (sync) + DAC transfer time + 2 (sync) + 1 cycles.
- All outputs are registered.

## Configuration
- `DAC_SEQ_AUTO_REFRESH_EN` defined:
  - A REFRESH_PERIOD down-counter runs while `ctrl[0] = 1`.
  - On expiry it sets all pending bits (same effect as a flush) and reloads.
  - Clearing `ctrl[0]` reloads the counter.
- Not defined:
  - No counter is built; `ctrl[0]` is still stored and readable but has no effect.
  - Flush through `data[1]` still works.

## Structure
- Package `dac_pkg` holds:
  - `DAC_CMD_NEW_VALUE` = 16'h0001.
  - Register offsets (VALUE_BASE, CTRL, ID, STATUS) and ID constant 16'h05EC.
  - FSM state enum: IDLE, ISSUE, WAIT_RISE, WAIT_FALL.
- Sub-module `sync_2ff` holds the dac_busy synchronizer.
- Round-robin selection is a combinational function inside the block.

## Test plan
- Write 0x123 to channel 2 → one strobe with data 0x0001_2123 and addr 0x4000. With a busy pulse modelled, pending reads back 0.
- Write channels 0, 3 and 7 in consecutive cycles → issues in order 0, 3, 7. The next strobe waits for each busy fall.
- Hold dac_busy low after ISSUE → after 64 cycles `err_cnt = 1`, the channel is re-pending and re-issued.
- Write channel 5 in the same cycle it is issued → old value sent first, then the new value in a second transfer.
- Assert reset during WAIT_FALL → all outputs 0 next cycle, status reads 0, and no issue occurs until a new write.
- With `DAC_SEQ_AUTO_REFRESH_EN`, REFRESH_PERIOD=100 and `ctrl[0] = 1` → all 8 channels are re-issued every sweep. Without the macro, no strobes occur.
